// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB I2C master: register map, STATUS bit
// positions and the bus state machine encoding.
package apb_i2c_pkg;

    localparam int REG_DATA     = 0;
    localparam int REG_SLAVE    = 1;
    localparam int REG_COUNT    = 2;
    localparam int REG_CMD      = 3;
    localparam int REG_STATUS   = 4;
    localparam int REG_PRESCALE = 5;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_ACK_ERR  = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_RX_VALID = 3;
    localparam int STAT_DONE     = 4;
    localparam int STAT_RX_OVR   = 5;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: tick is high for one cycle every prescale+1 cycles
// while enabled; the count restarts from zero whenever disabled.
module i2c_tick_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] cnt_reg;

    assign tick = en && (cnt_reg == prescale);

    // Free-running divider, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (!en || tick) begin
            cnt_reg <= 8'd0;
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/apb_i2c_master.sv
// APB-controlled single-master I2C engine. Every bit is split into four
// quarters: q0 SCL low (SDA set), q1/q2 SCL high (SDA sampled at the q1/q2
// boundary), q3 SCL low.
module apb_i2c_master
    import apb_i2c_pkg::*;
#(
    parameter int PRESCALE_RST = 24,
    parameter int ADDR_W       = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [7:0]        PWDATA,
    output logic              PREADY,
    output logic [7:0]        PRDATA,
    inout  wire               sda,
    inout  wire               scl
);

    localparam logic [ADDR_W-1:0] A_DATA     = ADDR_W'(REG_DATA);
    localparam logic [ADDR_W-1:0] A_SLAVE    = ADDR_W'(REG_SLAVE);
    localparam logic [ADDR_W-1:0] A_COUNT    = ADDR_W'(REG_COUNT);
    localparam logic [ADDR_W-1:0] A_CMD      = ADDR_W'(REG_CMD);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_PRESCALE = ADDR_W'(REG_PRESCALE);

    i2c_state_t state_reg;
    logic [1:0] q_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg, byte_cnt_reg;
    logic       ack_in_reg, wait_reg, sda_oe_reg, scl_oe_reg;
    logic [7:0] slave_reg, count_reg, prescale_reg, tx_hold_reg, rx_data_reg;
    logic       ack_err_reg, tx_full_reg, rx_valid_reg, done_reg, rx_ovr_reg;
    logic       busy, tick, apb_wr, apb_rd, sda_in;
    logic [7:0] status;

    assign busy   = (state_reg != IDLE);
    assign apb_wr = PSELx && PENABLE && PWRITE;
    assign apb_rd = PSELx && PENABLE && !PWRITE;
    assign PREADY = 1'b1;
    assign sda    = sda_oe_reg ? 1'b0 : 1'bz;
    assign scl    = scl_oe_reg ? 1'b0 : 1'bz;
    assign sda_in = sda;

    // The divider pauses while a write byte waits for DATA, so the first
    // quarter after the stall is full length.
    i2c_tick_gen u_tick (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .en       (busy && !wait_reg),
        .prescale (prescale_reg),
        .tick     (tick)
    );

    // Assemble STATUS from the individual flags.
    always_comb begin
        status                = 8'h00;
        status[STAT_BUSY]     = busy;
        status[STAT_ACK_ERR]  = ack_err_reg;
        status[STAT_TX_FULL]  = tx_full_reg;
        status[STAT_RX_VALID] = rx_valid_reg;
        status[STAT_DONE]     = done_reg;
        status[STAT_RX_OVR]   = rx_ovr_reg;
    end

    // Combinational read decode; idle bus reads as zero.
    always_comb begin
        PRDATA = 8'h00;
        if (PSELx) begin
            case (PADDR)
                A_DATA:     PRDATA = rx_data_reg;
                A_SLAVE:    PRDATA = slave_reg;
                A_COUNT:    PRDATA = count_reg;
                A_STATUS:   PRDATA = status;
                A_PRESCALE: PRDATA = prescale_reg;
                default:    PRDATA = 8'h00;
            endcase
        end
    end

    // Register file plus bus FSM. Clears come first so a same-cycle hardware
    // set wins; the DATA write comes last so a byte written during a load
    // stays pending.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= IDLE;
            q_reg        <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            byte_cnt_reg <= 8'd0;
            ack_in_reg   <= 1'b1;
            wait_reg     <= 1'b0;
            sda_oe_reg   <= 1'b0;
            scl_oe_reg   <= 1'b0;
            slave_reg    <= 8'h00;
            count_reg    <= 8'd1;
            prescale_reg <= 8'(PRESCALE_RST);
            tx_hold_reg  <= 8'h00;
            rx_data_reg  <= 8'h00;
            ack_err_reg  <= 1'b0;
            tx_full_reg  <= 1'b0;
            rx_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            rx_ovr_reg   <= 1'b0;
        end else begin
            if (apb_wr && !busy) begin
                if (PADDR == A_SLAVE)    slave_reg    <= PWDATA;
                if (PADDR == A_COUNT)    count_reg    <= PWDATA;
                if (PADDR == A_PRESCALE) prescale_reg <= PWDATA;
            end
            if (apb_wr && PADDR == A_STATUS) begin
                if (PWDATA[STAT_ACK_ERR]) ack_err_reg <= 1'b0;
                if (PWDATA[STAT_DONE])    done_reg    <= 1'b0;
                if (PWDATA[STAT_RX_OVR])  rx_ovr_reg  <= 1'b0;
            end
            if (apb_rd && PADDR == A_DATA) rx_valid_reg <= 1'b0;

            if (state_reg == IDLE) begin
                if (apb_wr && PADDR == A_CMD && PWDATA[0]) begin
                    state_reg    <= START;
                    q_reg        <= 2'd0;
                    shift_reg    <= slave_reg;
                    byte_cnt_reg <= (count_reg == 8'd0) ? 8'd1 : count_reg;
                    wait_reg     <= 1'b0;
                    sda_oe_reg   <= 1'b0;
                    scl_oe_reg   <= 1'b0;
                end
            end else if (wait_reg) begin
                if (tx_full_reg) begin
                    shift_reg   <= tx_hold_reg;
                    tx_full_reg <= 1'b0;
                    sda_oe_reg  <= !tx_hold_reg[7];
                    bit_cnt_reg <= 3'd7;
                    q_reg       <= 2'd0;
                    wait_reg    <= 1'b0;
                end
            end else if (tick) begin
                q_reg <= q_reg + 2'd1;
                if (q_reg == 2'd1) begin
                    if (state_reg == RD_DATA) shift_reg <= {shift_reg[6:0], sda_in};
                    else                      ack_in_reg <= sda_in;
                end
                case (state_reg)
                    START: begin
                        if (q_reg == 2'd0) sda_oe_reg <= 1'b1;
                        if (q_reg == 2'd2) scl_oe_reg <= 1'b1;
                        if (q_reg == 2'd3) begin
                            state_reg   <= ADDR;
                            bit_cnt_reg <= 3'd7;
                            sda_oe_reg  <= !shift_reg[7];
                        end
                    end
                    STOP: begin
                        if (q_reg == 2'd0) scl_oe_reg <= 1'b0;
                        if (q_reg == 2'd2) sda_oe_reg <= 1'b0;
                        if (q_reg == 2'd3) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        if (q_reg == 2'd0) scl_oe_reg <= 1'b0;
                        if (q_reg == 2'd2) scl_oe_reg <= 1'b1;
                        if (q_reg == 2'd3) begin
                            case (state_reg)
                                ADDR, WR_DATA: begin
                                    if (bit_cnt_reg == 3'd0) begin
                                        state_reg  <= (state_reg == ADDR) ? ADDR_ACK : WR_ACK;
                                        sda_oe_reg <= 1'b0;
                                    end else begin
                                        bit_cnt_reg <= bit_cnt_reg - 3'd1;
                                        shift_reg   <= {shift_reg[6:0], 1'b0};
                                        sda_oe_reg  <= !shift_reg[6];
                                    end
                                end
                                ADDR_ACK, WR_ACK: begin
                                    if (ack_in_reg) begin
                                        ack_err_reg <= 1'b1;
                                        state_reg   <= STOP;
                                        sda_oe_reg  <= 1'b1;
                                    end else if (state_reg == ADDR_ACK && slave_reg[0]) begin
                                        state_reg   <= RD_DATA;
                                        bit_cnt_reg <= 3'd7;
                                    end else if (state_reg == ADDR_ACK || byte_cnt_reg > 8'd1) begin
                                        if (state_reg == WR_ACK) byte_cnt_reg <= byte_cnt_reg - 8'd1;
                                        state_reg <= WR_DATA;
                                        wait_reg  <= 1'b1;
                                    end else begin
                                        state_reg  <= STOP;
                                        sda_oe_reg <= 1'b1;
                                    end
                                end
                                RD_DATA: begin
                                    if (bit_cnt_reg == 3'd0) begin
                                        rx_data_reg  <= shift_reg;
                                        rx_valid_reg <= 1'b1;
                                        if (rx_valid_reg) rx_ovr_reg <= 1'b1;
                                        state_reg    <= RD_ACK;
                                        sda_oe_reg   <= (byte_cnt_reg > 8'd1);
                                    end else begin
                                        bit_cnt_reg <= bit_cnt_reg - 3'd1;
                                    end
                                end
                                RD_ACK: begin
                                    if (byte_cnt_reg > 8'd1) begin
                                        byte_cnt_reg <= byte_cnt_reg - 8'd1;
                                        state_reg    <= RD_DATA;
                                        bit_cnt_reg  <= 3'd7;
                                        sda_oe_reg   <= 1'b0;
                                    end else begin
                                        state_reg  <= STOP;
                                        sda_oe_reg <= 1'b1;
                                    end
                                end
                                default: state_reg <= IDLE;
                            endcase
                        end
                    end
                endcase
            end

            if (apb_wr && PADDR == A_DATA) begin
                tx_hold_reg <= PWDATA;
                tx_full_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_i2c_master.sv
// Bench for apb_i2c_master: APB driver, I2C slave model and bus monitor.
// Expected bus events are queued when a transfer is launched and popped
// against the monitor's observations once the transfer ends.
module tb_apb_i2c_master;

    localparam logic [7:0] R_DATA = 8'h00, R_SLAVE = 8'h01, R_COUNT = 8'h02;
    localparam logic [7:0] R_CMD = 8'h03, R_STATUS = 8'h04, R_PRESCALE = 8'h05;
    localparam int EV_START = 'h400;
    localparam int EV_STOP  = 'h800;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
    logic       PREADY;
    logic [7:0] PRDATA;
    wire        sda, scl;
    logic       slave_low = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slave_low ? 1'b0 : 1'bz;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];
    int obs_q[$];
    int rd_q[$];
    bit ack_en = 1'b1;
    int bitcnt = 0;
    int cyc = 0;
    int last_rise = 0;
    int period = 0;

    apb_i2c_master #(.PRESCALE_RST(24), .ADDR_W(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSELx   (PSELx),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .sda     (sda),
        .scl     (scl)
    );

    always #5 PCLK = ~PCLK;

    // Bus monitor and slave model, sampled on the falling PCLK edge.
    initial begin
        logic       prev_sda, prev_scl, rw, addr_ok, nacked;
        logic [8:0] sh;
        logic [7:0] tx_byte;
        int         byte_idx;
        prev_sda = 1'b1; prev_scl = 1'b1; rw = 1'b0; addr_ok = 1'b0;
        nacked = 1'b0; sh = 9'h0; tx_byte = 8'hFF; byte_idx = 0;
        forever begin
            @(negedge PCLK);
            cyc++;
            if (!PRESETn) begin
                bitcnt = 0; byte_idx = 0; slave_low = 1'b0; nacked = 1'b0;
                addr_ok = 1'b0; rw = 1'b0; prev_sda = 1'b1; prev_scl = 1'b1;
            end else begin
                if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
                    obs_q.push_back(EV_START);
                    bitcnt = 0; byte_idx = 0; nacked = 1'b0; addr_ok = 1'b0; rw = 1'b0;
                end else if (scl === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
                    obs_q.push_back(EV_STOP);
                end else if (scl === 1'b1 && prev_scl === 1'b0) begin
                    period = cyc - last_rise;
                    last_rise = cyc;
                    sh = {sh[7:0], sda};
                    bitcnt++;
                    if (bitcnt == 9) begin
                        obs_q.push_back(int'({sh[0], sh[8:1]}));
                        if (byte_idx == 0) begin
                            rw = sh[1];
                            addr_ok = !sh[0];
                        end else if (rw && sh[0]) begin
                            nacked = 1'b1;
                        end
                        byte_idx++;
                        bitcnt = 0;
                    end
                end else if (scl === 1'b0 && prev_scl === 1'b1) begin
                    slave_low = 1'b0;
                    if (bitcnt == 8) begin
                        if ((byte_idx == 0 || !rw) && ack_en) slave_low = 1'b1;
                    end else if (rw && addr_ok && !nacked && byte_idx >= 1) begin
                        if (bitcnt == 0) tx_byte = (rd_q.size() > 0) ? 8'(rd_q.pop_front()) : 8'hFF;
                        slave_low = !tx_byte[7-bitcnt];
                    end
                end
                prev_sda = sda;
                prev_scl = scl;
            end
        end
    end

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge PCLK);
        PSELx = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge PCLK);
        PSELx = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(negedge PCLK);
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic [7:0] st;
        int n;
        n = 0;
        do begin
            apb_read(R_STATUS, st);
            n++;
        end while (st[0] && n < 2000);
        tests_run++;
        if (st[0]) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%0b after %0d polls, required 0", name, st[0], n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        tests_run++;
        if (PRDATA !== 8'h00 || PREADY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_apb: PRDATA=%h PREADY=%b, required 00/1", PRDATA, PREADY);
        end
        tests_run++;
        if (sda !== 1'b1 || scl !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_lines: sda=%b scl=%b, required released (1/1)", sda, scl);
        end
        PRESETn = 1'b1;
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL reset_status: got %h, required 00", v); end
        apb_read(R_PRESCALE, v);
        tests_run++;
        if (v !== 8'd24) begin tests_failed++; $display("FAIL reset_prescale: got %0d, required 24", v); end
        apb_read(R_COUNT, v);
        tests_run++;
        if (v !== 8'd1) begin tests_failed++; $display("FAIL reset_count: got %0d, required 1", v); end
        apb_read(R_SLAVE, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL reset_slave: got %h, required 00", v); end
        $display("[TB] reset checks done");
    endtask

    task automatic test_write_one();
        logic [7:0] v;
        int e, o;
        apb_write(R_PRESCALE, 8'd4);
        apb_write(R_SLAVE, 8'hA0);
        apb_write(R_DATA, 8'h5A);
        exp_q.push_back(EV_START); exp_q.push_back('h0A0);
        exp_q.push_back('h05A);    exp_q.push_back(EV_STOP);
        apb_write(R_CMD, 8'h01);
        wait_idle("write1");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL write1_bus: got %h, required %h", o, e); end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL write1_extra: %0d extra events, required 0", obs_q.size()); obs_q.delete(); end
        tests_run++;
        if (period != 20) begin tests_failed++; $display("FAIL write1_scl_period: got %0d, required 20", period); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h10) begin tests_failed++; $display("FAIL write1_status: got %h, required 10", v); end
        apb_write(R_STATUS, 8'h10);
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL write1_w1c: got %h, required 00", v); end
        $display("[TB] write-1-byte transaction checked, period=%0d", period);
    endtask

    task automatic test_addr_nack();
        logic [7:0] v;
        int e, o;
        ack_en = 1'b0;
        apb_write(R_SLAVE, 8'h42);
        exp_q.push_back(EV_START); exp_q.push_back('h142); exp_q.push_back(EV_STOP);
        apb_write(R_CMD, 8'h01);
        wait_idle("nack");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL nack_bus: got %h, required %h", o, e); end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL nack_extra: %0d extra events, required 0", obs_q.size()); obs_q.delete(); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h12) begin tests_failed++; $display("FAIL nack_status: got %h, required 12", v); end
        apb_write(R_STATUS, 8'h12);
        ack_en = 1'b1;
        $display("[TB] address-NACK transaction checked");
    endtask

    task automatic test_read_two();
        logic [7:0] v;
        int e, o;
        apb_write(R_SLAVE, 8'hA1);
        apb_write(R_COUNT, 8'd2);
        rd_q.push_back('h3C); rd_q.push_back('hC3);
        exp_q.push_back(EV_START); exp_q.push_back('h0A1); exp_q.push_back('h03C);
        exp_q.push_back('h1C3);    exp_q.push_back(EV_STOP);
        apb_write(R_CMD, 8'h01);
        wait_idle("read2");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL read2_bus: got %h, required %h", o, e); end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL read2_extra: %0d extra events, required 0", obs_q.size()); obs_q.delete(); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h38) begin tests_failed++; $display("FAIL read2_status: got %h, required 38", v); end
        apb_read(R_DATA, v);
        tests_run++;
        if (v !== 8'hC3) begin tests_failed++; $display("FAIL read2_data: got %h, required c3", v); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h30) begin tests_failed++; $display("FAIL read2_rxvalid_clr: got %h, required 30", v); end
        apb_write(R_STATUS, 8'h30);
        $display("[TB] read-2-byte transaction checked");
    endtask

    task automatic test_stall();
        logic [7:0] v;
        int e, o, n;
        apb_write(R_SLAVE, 8'hA0);
        apb_write(R_DATA, 8'h11);
        exp_q.push_back(EV_START); exp_q.push_back('h0A0); exp_q.push_back('h011);
        exp_q.push_back('h022);    exp_q.push_back(EV_STOP);
        apb_write(R_CMD, 8'h01);
        n = 0;
        while (obs_q.size() < 3 && n < 3000) begin @(negedge PCLK); n++; end
        tests_run++;
        if (obs_q.size() < 3) begin tests_failed++; $display("FAIL stall_byte1_timeout: %0d events, required 3", obs_q.size()); end
        repeat (200) @(negedge PCLK);
        tests_run++;
        if (scl !== 1'b0) begin tests_failed++; $display("FAIL stall_scl_low: scl=%b, required 0", scl); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h01) begin tests_failed++; $display("FAIL stall_status: got %h, required 01", v); end
        apb_write(R_SLAVE, 8'h55);
        apb_write(R_CMD, 8'h01);
        apb_write(R_DATA, 8'h22);
        wait_idle("stall");
        repeat (300) @(negedge PCLK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL stall_bus: got %h, required %h", o, e); end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("FAIL stall_extra: %0d extra events, required 0", obs_q.size()); obs_q.delete(); end
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h10) begin tests_failed++; $display("FAIL stall_status_end: got %h, required 10", v); end
        apb_read(R_SLAVE, v);
        tests_run++;
        if (v !== 8'hA0) begin tests_failed++; $display("FAIL busy_slave_write: got %h, required a0", v); end
        apb_write(R_STATUS, 8'h10);
        $display("[TB] stalled 2-byte write checked");
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int n;
        apb_write(R_DATA, 8'h33);
        apb_write(R_CMD, 8'h01);
        n = 0;
        while (bitcnt < 3 && n < 3000) begin @(negedge PCLK); n++; end
        tests_run++;
        if (bitcnt < 3) begin tests_failed++; $display("FAIL midreset_reach_addr: bitcnt=%0d, required >=3", bitcnt); end
        PRESETn = 1'b0;
        #1;
        tests_run++;
        if (sda !== 1'b1 || scl !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_release: sda=%b scl=%b, required 1/1", sda, scl);
        end
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        obs_q.delete();
        apb_read(R_STATUS, v);
        tests_run++;
        if (v !== 8'h00) begin tests_failed++; $display("FAIL midreset_status: got %h, required 00", v); end
        repeat (100) @(negedge PCLK);
        tests_run++;
        if (obs_q.size() != 0 || scl !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_quiet: %0d bus events scl=%b, required 0/1", obs_q.size(), scl);
        end
        $display("[TB] reset during address phase checked");
    endtask

    initial begin
        test_reset();
        test_write_one();
        test_addr_nack();
        test_read_two();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_i2c_master.md
APB_I2C_MASTER -- requirements
Module: apb_i2c_master

Interface
REQ-001 SHALL have parameter PRESCALE_RST, default 24, reset value of PRESCALE register.
REQ-002 SHALL have parameter ADDR_W, default 8, PADDR width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 PCLK  input  1  sole clock; all logic rises on posedge.
REQ-005 PRESETn  input  1  asynchronous active-low reset.
REQ-006 PSELx  input  1  APB select.
REQ-007 PENABLE  input  1  APB access phase.
REQ-008 PWRITE  input  1  1=write, 0=read.
REQ-009 PADDR  input  ADDR_W  register address.
REQ-010 PWDATA  input  8  write data.
REQ-011 PREADY  output  1  always 1 (zero wait states).
REQ-012 PRDATA  output  8  read data, valid during access phase.
REQ-013 sda  inout  1  I2C data, open-drain: drives 0 or Z only.
REQ-014 scl  inout  1  I2C clock, open-drain: drives 0 or Z only.

Function
REQ-015 APB write SHALL commit on the PCLK edge where PSELx&PENABLE&PWRITE=1; read decode SHALL be combinational on PADDR when PSELx=1, else PRDATA=0.
REQ-016 Register map: 0x00 DATA (W: TX holding byte, sets tx_full; R: RX byte, clears rx_valid); 0x01 SLAVE ({addr[6:0], rw}); 0x02 COUNT (bytes per transfer, 0 treated as 1); 0x03 CMD (W bit0=start); 0x04 STATUS; 0x05 PRESCALE; unmapped reads return 0, unmapped writes ignored.
REQ-017 STATUS bits: [0] busy, [1] ack_err (sticky, W1C), [2] tx_full, [3] rx_valid, [4] done (sticky, W1C), [5] rx_overrun (sticky, W1C).
REQ-018 Quarter-bit tick SHALL pulse every PRESCALE+1 PCLK cycles while busy; SCL period = 4*(PRESCALE+1) PCLK cycles.
REQ-019 FSM states: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP.
REQ-020 IDLE->START on CMD.start write when not busy; start while busy SHALL be ignored.
REQ-021 START: SDA falls while SCL high, then SCL low; ADDR: shift SLAVE byte MSB first, SDA changes only while SCL low.
REQ-022 ADDR_ACK: sample SDA at SCL high; 0 -> WR_DATA (rw=0) or RD_DATA (rw=1); 1 -> set ack_err, go STOP.
REQ-023 WR_DATA: if tx_full=0 at byte start, hold SCL low until DATA is written; load byte, clear tx_full, shift MSB first.
REQ-024 WR_ACK: NACK -> ack_err, STOP; ACK -> next byte if remaining count>0, else STOP.
REQ-025 RD_DATA: release SDA, sample 8 bits at SCL high; store to RX, set rx_valid; if rx_valid already 1, set rx_overrun and overwrite.
REQ-026 RD_ACK: master drives ACK (0) for all but last byte, NACK (Z) on last, then STOP.
REQ-027 STOP: SDA low while SCL low, release SCL, then release SDA while SCL high; set done, clear busy, return IDLE.
REQ-028 SLAVE, COUNT, PRESCALE writes while busy SHALL be ignored.
REQ-029 Simultaneous W1C write and hardware set of the same sticky bit: set wins.

Reset
REQ-030 PRESETn=0 SHALL force IDLE, sda=Z, scl=Z, PREADY=1, PRDATA=0, SLAVE=0, COUNT=1, PRESCALE=PRESCALE_RST, all STATUS bits 0.
REQ-031 Reset mid-transfer SHALL abort immediately, releasing both lines with no STOP generated.

Structure
REQ-032 Package apb_i2c_pkg SHALL hold register address constants, STATUS bit indices, and the FSM state enum.
REQ-033 Sub-module i2c_tick_gen SHALL generate the quarter-bit tick from PRESCALE; all else in apb_i2c_master.

Verification
REQ-034 Reset: PRESETn low -> PRDATA=0, PREADY=1, STATUS=0x00, PRESCALE reads 24, COUNT reads 1.
REQ-035 Write 1 byte: PRESCALE=4, SLAVE=0xA0, DATA=0x5A, CMD=1, slave ACKs -> bus shows START, 0xA0, ACK, 0x5A, ACK, STOP; SCL period 20 PCLK; STATUS.done=1.
REQ-036 Address NACK: SLAVE=0x42, slave leaves SDA high -> STOP after 9th clock, STATUS=0x12 (ack_err|done).
REQ-037 Read 2 bytes: SLAVE=0xA1, COUNT=2, slave sends 0x3C,0xC3 -> master ACKs first, NACKs second; second unread read yields rx_overrun=1, DATA reads 0xC3.
REQ-038 Stall: COUNT=2, only first DATA written -> SCL held low after byte 1 ACK until second DATA write, then transfer completes.
REQ-039 Reset asserted mid-ADDR -> sda and scl Z within one PCLK edge, busy=0.
